// File: rtl/tdm_pkg.sv
// Definitions shared by both ends of the TDM serial link:
// frame width default, receiver state encoding and lane index type.
package tdm_pkg;

  localparam int TDM_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tdm_state_t;

  typedef logic [$clog2(TDM_WIDTH)-1:0] lane_idx_t;

endpackage

// File: rtl/tdm_addr_latch.sv
// Clocked addressable latch: one bit written per cycle at idx, with a clear.
// A clear and a write in the same cycle leave only the written bit set.
module tdm_addr_latch
  import tdm_pkg::*;
#(
  parameter int WIDTH = TDM_WIDTH,
  localparam int SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic             clr,
  input  logic [SEL_W-1:0] idx,
  input  logic             d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_next;

  always_comb begin
    q_next = clr ? '0 : q;
    for (int i = 0; i < WIDTH; i++) begin
      if (we && idx == SEL_W'(i)) q_next[i] = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= q_next;
  end

endmodule

// File: rtl/tdm_demux_deserializer.sv
// Receive end of the 8:1 TDM link: rebuilds one frame lane by lane and
// hands complete frames to a valid/ready consumer.
module tdm_demux_deserializer
  import tdm_pkg::*;
#(
  parameter int WIDTH = TDM_WIDTH,
  localparam int SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_i,
  input  logic             bit_valid_i,
  input  logic             sync_i,
  input  logic             clear_i,
  output logic [SEL_W-1:0] sel_o,
  output logic [WIDTH-1:0] word_o,
  output logic             word_valid_o,
  input  logic             word_ready_i,
  output logic             overrun_o,
  output logic             sync_err_o
);

  localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(WIDTH - 1);

  tdm_state_t       state;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] frame_word;
  logic [WIDTH-1:0] pending;
  logic             pending_valid;
  logic             latch_we;
  logic             latch_clr;
  logic             frame_done;
  logic             resync;
  logic             missing_sync;
  logic             overrun_set;

  always_comb begin
    latch_we     = 1'b0;
    latch_clr    = 1'b0;
    frame_done   = 1'b0;
    resync       = 1'b0;
    missing_sync = 1'b0;
    if (bit_valid_i) begin
      if (state == IDLE) begin
        latch_we = sync_i;
      end else if (sync_i) begin
        latch_we = 1'b1;
        if (sel_o != '0) begin
          latch_clr = 1'b1;
          resync    = 1'b1;
        end
      end else if (sel_o != '0) begin
        latch_we   = 1'b1;
        frame_done = (sel_o == LAST_LANE);
      end else begin
        missing_sync = 1'b1;
      end
    end
  end

  // The completed frame includes the bit arriving this cycle, which the
  // shadow register only absorbs on this same edge.
  always_comb begin
    frame_word            = shadow;
    frame_word[WIDTH-1]   = bit_i;
  end

  tdm_addr_latch #(.WIDTH(WIDTH)) u_shadow (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (latch_we),
    .clr   (latch_clr),
    .idx   (sync_i ? '0 : sel_o),
    .d     (bit_i),
    .q     (shadow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel_o <= '0;
    end else if (bit_valid_i) begin
      case (state)
        IDLE: begin
          if (sync_i) begin
            state <= SHIFT;
            sel_o <= SEL_W'(1);
          end
        end
        SHIFT: begin
          if (sync_i)               sel_o <= SEL_W'(1);
          else if (sel_o == '0)     state <= IDLE;
          else if (sel_o == LAST_LANE) sel_o <= '0;
          else                      sel_o <= sel_o + SEL_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign overrun_set = pending_valid && word_valid_o && !word_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending       <= '0;
      pending_valid <= 1'b0;
      word_o        <= '0;
      word_valid_o  <= 1'b0;
      overrun_o     <= 1'b0;
      sync_err_o    <= 1'b0;
    end else begin
      pending_valid <= frame_done;
      if (frame_done) pending <= frame_word;

      if (pending_valid) begin
        if (!word_valid_o || word_ready_i) begin
          word_o       <= pending;
          word_valid_o <= 1'b1;
        end
      end else if (word_valid_o && word_ready_i) begin
        word_valid_o <= 1'b0;
      end

      // Set events take priority over a simultaneous clear.
      overrun_o  <= overrun_set | (overrun_o & ~clear_i);
      sync_err_o <= resync | missing_sync | (sync_err_o & ~clear_i);
    end
  end

endmodule
